// File: rtl/soundweb_tx_sequencer_if.sv
// Byte stream between the Soundweb transmit sequencer and the serial transmitter.
// The sender owns tx_data/tx_valid; the sink answers with tx_ready.
interface soundweb_tx_sequencer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/soundweb_tx_sequencer.sv
// Soundweb transmit sequencer: snapshots one encoded packet on a start edge,
// streams it byte by byte until the ETX terminator (or abort / buffer end),
// then reports the outcome in the status word and pulses irq for one cycle.
module soundweb_tx_sequencer #(
  parameter int         MAX_BYTES = 29,
  parameter logic [7:0] STX       = 8'h02,
  parameter logic [7:0] ETX       = 8'h03
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             ctl_in_i,
  input  logic [8*MAX_BYTES-1:0]  enc_packet_i,
  output logic [31:0]             status_o,
  output logic                    irq_o,
  soundweb_tx_sequencer_if.master tx_if
);

  // Byte index and count share a 5-bit field in the status word.
  localparam logic [4:0] LAST_IDX = 5'(MAX_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_SEND    = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e     state_q;
  logic       start_q;
  logic [4:0] idx_q;
  logic [4:0] count_q;
  logic       done_q;
  logic       overflow_q;
  logic       aborted_q;
  logic       dropped_q;
  logic       bad_stx_q;
  logic       irq_q;
  logic       tx_valid_q;
  logic [7:0] tx_data_q;
  logic [7:0] buf_q [MAX_BYTES];

  logic       start_edge_d;
  logic       abort_d;
  logic       busy_d;
  logic       hs_d;
  logic       etx_hit_d;
  logic       last_d;
  logic [4:0] idx_inc_d;
  logic       unused_ctl_d;

  assign start_edge_d = ctl_in_i[0] & ~start_q;
  assign abort_d      = ctl_in_i[1];
  assign busy_d       = (state_q == S_CAPTURE) || (state_q == S_SEND);
  assign hs_d         = tx_valid_q & tx_if.tx_ready;
  // tx_data_q always mirrors buf_q[idx_q] while sending.
  assign etx_hit_d    = (tx_data_q == ETX) && (idx_q != 5'd0);
  assign last_d       = (idx_q == LAST_IDX);
  assign idx_inc_d    = idx_q + 5'd1;
  assign unused_ctl_d = ^ctl_in_i[31:2];

  assign tx_if.tx_valid = tx_valid_q;
  assign tx_if.tx_data  = tx_data_q;
  assign irq_o          = irq_q;
  assign status_o       = {19'd0, count_q, 2'd0, bad_stx_q, dropped_q,
                           aborted_q, overflow_q, done_q, busy_d};

  // Packet snapshot: taken only when a start is accepted, so later encoder changes cannot leak in.
  always_ff @(posedge clk) begin
    if ((state_q == S_IDLE) && start_edge_d) begin
      for (int k = 0; k < MAX_BYTES; k++) begin
        buf_q[k] <= enc_packet_i[8*k +: 8];
      end
    end
  end

  // Sequencing FSM with registered stream, status and interrupt outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      idx_q      <= 5'd0;
      count_q    <= 5'd0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      aborted_q  <= 1'b0;
      dropped_q  <= 1'b0;
      bad_stx_q  <= 1'b0;
      irq_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      start_q <= ctl_in_i[0];
      irq_q   <= 1'b0;
      // Starts arriving while a packet is in flight (including DONE) are not queued.
      if (start_edge_d && (state_q != S_IDLE)) begin
        dropped_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (start_edge_d) begin
            idx_q      <= 5'd0;
            count_q    <= 5'd0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            aborted_q  <= 1'b0;
            dropped_q  <= 1'b0;
            bad_stx_q  <= 1'b0;
            state_q    <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (abort_d) begin
            aborted_q <= 1'b1;
            done_q    <= 1'b1;
            irq_q     <= 1'b1;
            state_q   <= S_DONE;
          end else if (buf_q[0] != STX) begin
            bad_stx_q <= 1'b1;
            done_q    <= 1'b1;
            irq_q     <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= buf_q[0];
            state_q    <= S_SEND;
          end
        end
        S_SEND: begin
          // The presented byte is held until accepted; abort is only looked at on acceptance.
          if (hs_d) begin
            count_q <= idx_inc_d;
            if (etx_hit_d || abort_d || last_d) begin
              if (!etx_hit_d) begin
                if (abort_d) begin
                  aborted_q <= 1'b1;
                end else begin
                  overflow_q <= 1'b1;
                end
              end
              tx_valid_q <= 1'b0;
              tx_data_q  <= 8'h00;
              done_q     <= 1'b1;
              irq_q      <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              idx_q     <= idx_inc_d;
              tx_data_q <= buf_q[idx_inc_d];
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          tx_valid_q <= 1'b0;
          tx_data_q  <= 8'h00;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soundweb_tx_sequencer.sv
// Scoreboard bench for soundweb_tx_sequencer: each run's expected handshakes and
// completion record come from a cycle-level model of the packet rules; a
// negedge monitor checks the DUT against those queues independently.
module tb_soundweb_tx_sequencer;
  localparam int MB = 29;
  localparam int PL = 128;
  localparam logic [7:0] STX = 8'h02;
  localparam logic [7:0] ETX = 8'h03;

  logic            clk = 1'b0;
  logic            reset;
  logic [31:0]     ctl_in;
  logic [8*MB-1:0] enc_packet;
  logic [31:0]     status;
  logic            irq;

  soundweb_tx_sequencer_if tx_if ();

  soundweb_tx_sequencer #(.MAX_BYTES(MB), .STX(STX), .ETX(ETX)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .ctl_in_i     (ctl_in),
    .enc_packet_i (enc_packet),
    .status_o     (status),
    .irq_o        (irq),
    .tx_if        (tx_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [7:0] data; int cyc; } hs_t;
  typedef struct { logic [31:0] st; int cyc; } cmp_t;
  hs_t  exp_hs[$];
  cmp_t exp_done[$];

  logic [7:0] pkt [MB];
  bit rdy [PL];
  bit abt [PL];
  bit strt [PL];
  int snap_off;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: compares every handshake and every irq against the scoreboard.
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", {31'd0, tx_if.tx_valid}, 32'd1);
        chk("stall_data_held", {24'd0, tx_if.tx_data}, {24'd0, prev_data});
      end
      prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
      prev_data  = tx_if.tx_data;
      if (!tx_if.tx_valid) chk("idle_data_zero", {24'd0, tx_if.tx_data}, 32'd0);
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        if (exp_hs.size() == 0) begin
          chk("unexpected_handshake", {24'd0, tx_if.tx_data}, 32'hFFFF_FFFF);
        end else begin
          hs_t h;
          h = exp_hs.pop_front();
          chk("hs_data", {24'd0, tx_if.tx_data}, {24'd0, h.data});
          chk("hs_cycle", cyc, h.cyc);
        end
      end
      if (irq) begin
        if (exp_done.size() == 0) begin
          chk("unexpected_irq", status, 32'hFFFF_FFFF);
        end else begin
          cmp_t c;
          c = exp_done.pop_front();
          chk("done_status", status, c.st);
          chk("irq_cycle", cyc, c.cyc);
        end
      end
    end
  end

  task automatic clear_pat();
    for (int k = 0; k < PL; k++) begin
      rdy[k]  = 1'b1;
      abt[k]  = 1'b0;
      strt[k] = 1'b1;
    end
    snap_off = -1;
  endtask

  task automatic load_pkt();
    for (int k = 0; k < MB; k++) enc_packet[8*k +: 8] = pkt[k];
  endtask

  task automatic set_normal();
    logic [7:0] b [12] = '{8'h02, 8'h8D, 8'h1E, 8'h00, 8'h01, 8'h00,
                           8'h00, 8'h03, 8'h00, 8'h01, 8'h00, 8'h03};
    for (int k = 0; k < MB; k++) pkt[k] = (k < 12) ? b[k] : 8'h00;
  endtask

  // Reference: walk cycle offsets from the start edge applying the packet rules.
  task automatic model_run(input int n, output int done_off);
    int cnt = 0;
    int t;
    int i;
    bit ovf = 0, abo = 0, bad = 0, drp = 0;
    if (abt[1]) begin
      abo = 1; done_off = 2;
    end else if (pkt[0] != STX) begin
      bad = 1; done_off = 2;
    end else begin
      i = 0;
      t = 2;
      done_off = -1;
      while (done_off < 0 && t < PL - 4) begin
        if (rdy[t]) begin
          exp_hs.push_back('{pkt[i], n + t});
          cnt = i + 1;
          if (pkt[i] == ETX && i != 0) done_off = t + 1;
          else if (abt[t]) begin abo = 1; done_off = t + 1; end
          else if (i == MB - 1) begin ovf = 1; done_off = t + 1; end
          else i++;
        end
        t++;
      end
      if (done_off < 0) done_off = PL - 4;
    end
    for (int k = 1; k <= done_off; k++) if (strt[k] && !strt[k-1]) drp = 1;
    exp_done.push_back('{(32'(cnt) << 8) | (32'(bad) << 5) | (32'(drp) << 4) |
                         (32'(abo) << 3) | (32'(ovf) << 2) | 32'h2, n + done_off});
  endtask

  task automatic run_packet();
    int n;
    int done_off;
    load_pkt();
    @(posedge clk); #1;
    n = cyc;
    model_run(n, done_off);
    for (int off = 0; off <= done_off + 2; off++) begin
      ctl_in         = {30'd0, abt[off], strt[off]};
      tx_if.tx_ready = rdy[off];
      if (off == snap_off) enc_packet = {8{$urandom()}};
      @(posedge clk); #1;
    end
    ctl_in         = 32'd0;
    tx_if.tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    ctl_in         = 32'd0;
    enc_packet     = '0;
    tx_if.tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_status", status, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk("reset_valid", {31'd0, tx_if.tx_valid}, 32'd0);
    chk("reset_data", {24'd0, tx_if.tx_data}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_status", status, 32'd0);

    // Normal packet.
    clear_pat(); set_normal(); run_packet();
    // Backpressure on byte 5 (presented at offset 7).
    clear_pat(); set_normal(); rdy[7] = 0; rdy[8] = 0; rdy[9] = 0; run_packet();
    // Overflow: no terminator anywhere.
    clear_pat();
    for (int k = 0; k < MB; k++) pkt[k] = (k == 0) ? STX : 8'h55;
    run_packet();
    // Bad STX.
    clear_pat(); set_normal(); pkt[0] = 8'h7F; run_packet();
    // Snapshot plus dropped start during SEND.
    clear_pat(); set_normal(); snap_off = 3; strt[4] = 0; run_packet();
    // Abort while byte 3 is stalled.
    clear_pat(); set_normal(); rdy[5] = 0; rdy[6] = 0;
    for (int k = 6; k < PL; k++) abt[k] = 1;
    run_packet();
    // Abort already high at CAPTURE.
    clear_pat(); set_normal();
    for (int k = 0; k < PL; k++) abt[k] = 1;
    run_packet();
    // Randomized packets and backpressure.
    for (int r = 0; r < 8; r++) begin
      int len;
      clear_pat();
      len = $urandom_range(2, MB - 1);
      for (int k = 0; k < MB; k++) pkt[k] = 8'($urandom());
      pkt[0] = STX;
      for (int k = 1; k < len - 1; k++) while (pkt[k] == ETX) pkt[k] = 8'($urandom());
      pkt[len-1] = ETX;
      for (int k = 0; k < PL; k++) rdy[k] = ($urandom_range(0, 3) != 0);
      run_packet();
    end

    // Reset mid-SEND: the stalled byte must vanish with reset, not at a clock edge.
    clear_pat(); set_normal(); load_pkt();
    tx_if.tx_ready = 1'b0;
    ctl_in = 32'd1;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_valid", {31'd0, tx_if.tx_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_valid", {31'd0, tx_if.tx_valid}, 32'd0);
    chk("async_reset_data", {24'd0, tx_if.tx_data}, 32'd0);
    chk("async_reset_status", status, 32'd0);
    chk("async_reset_irq", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    ctl_in = 32'd0;
    reset  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("left_handshakes", exp_hs.size(), 32'd0);
    chk("left_completions", exp_done.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
